// File: rtl/trig_cfg_pkg.sv
// Shared types and constants for the trigger configuration sequencer.
package trig_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RRESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int REG_STRIDE = 4;

endpackage

// File: rtl/trig_cfg_sequencer.sv
// Writes NUM_REGS trigger registers over AXI4-Lite, optionally reads them back
// for verification when TRIG_CFG_READBACK_EN is defined; aborts on first failure.
//
// Handshake rule: every VALID is a function of registered state only and is held
// until the cycle in which its READY is sampled high; BREADY/RREADY are high for
// the whole of their response state.
module trig_cfg_sequencer
  import trig_cfg_pkg::*;
#(
  parameter int NUM_REGS           = 4,
  parameter int BASE_ADDR          = 0,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                                           ACLK,
  input  logic                                           ARESETN,
  input  logic                                           start,
  input  logic [NUM_REGS*32-1:0]                         cfg_data,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           err,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] err_idx,
  output state_e                                         dbg_state,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                  M_AXI_AWADDR,
  output logic [2:0]                                     M_AXI_AWPROT,
  output logic                                           M_AXI_AWVALID,
  input  logic                                           M_AXI_AWREADY,
  output logic [31:0]                                    M_AXI_WDATA,
  output logic [3:0]                                     M_AXI_WSTRB,
  output logic                                           M_AXI_WVALID,
  input  logic                                           M_AXI_WREADY,
  input  logic [1:0]                                     M_AXI_BRESP,
  input  logic                                           M_AXI_BVALID,
  output logic                                           M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                  M_AXI_ARADDR,
  output logic [2:0]                                     M_AXI_ARPROT,
  output logic                                           M_AXI_ARVALID,
  input  logic                                           M_AXI_ARREADY,
  input  logic [31:0]                                    M_AXI_RDATA,
  input  logic [1:0]                                     M_AXI_RRESP,
  input  logic                                           M_AXI_RVALID,
  output logic                                           M_AXI_RREADY
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                          state, state_d;
  logic [IDX_W-1:0]                idx;
  logic [31:0]                     regs_q [NUM_REGS];
  logic                            aw_done, w_done;
  logic                            aw_fire, w_fire, last;
  logic                            fail, advance, to_read;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   reg_addr;

  assign aw_fire  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_fire   = M_AXI_WVALID & M_AXI_WREADY;
  assign last     = (idx == IDX_W'(NUM_REGS - 1));
  assign reg_addr = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + REG_STRIDE * int'(idx));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    fail    = 1'b0;
    advance = 1'b0;
    to_read = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_d = ST_WADDR;
      // AW and W complete independently; move on once both are done.
      ST_WADDR: if ((aw_done | aw_fire) && (w_done | w_fire)) state_d = ST_WRESP;
      ST_WRESP: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != OKAY) begin
          fail    = 1'b1;
          state_d = ST_DONE;
        end else if (!last) begin
          advance = 1'b1;
          state_d = ST_WADDR;
        end else begin
`ifdef TRIG_CFG_READBACK_EN
          to_read = 1'b1;
          state_d = ST_RADDR;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef TRIG_CFG_READBACK_EN
      ST_RADDR: if (M_AXI_ARREADY) state_d = ST_RRESP;
      ST_RRESP: if (M_AXI_RVALID) begin
        if (M_AXI_RRESP != OKAY || M_AXI_RDATA != regs_q[idx]) begin
          fail    = 1'b1;
          state_d = ST_DONE;
        end else if (!last) begin
          advance = 1'b1;
          state_d = ST_RADDR;
        end else begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx     <= '0;
      err     <= 1'b0;
      err_idx <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= cfg_data[32*k +: 32];
        idx <= '0;
        err <= 1'b0;
      end
      if (advance) idx <= idx + 1'b1;
      if (to_read) idx <= '0;
      if (fail) begin
        err     <= 1'b1;
        err_idx <= idx;
      end
      // Completion flags only live while WADDR persists, so each register starts clean.
      aw_done <= (state == ST_WADDR) && (state_d == ST_WADDR) && (aw_done | aw_fire);
      w_done  <= (state == ST_WADDR) && (state_d == ST_WADDR) && (w_done | w_fire);
    end
  end

  assign dbg_state     = state;
  assign busy          = (state == ST_WADDR) || (state == ST_WRESP) ||
                         (state == ST_RADDR) || (state == ST_RRESP);
  assign done          = (state == ST_DONE);
  assign M_AXI_AWVALID = (state == ST_WADDR) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WADDR) && !w_done;
  assign M_AXI_AWADDR  = M_AXI_AWVALID ? reg_addr : '0;
  assign M_AXI_WDATA   = M_AXI_WVALID ? regs_q[idx] : '0;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_BREADY  = (state == ST_WRESP);
  assign M_AXI_ARPROT  = 3'b000;

`ifdef TRIG_CFG_READBACK_EN
  assign M_AXI_ARVALID = (state == ST_RADDR);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? reg_addr : '0;
  assign M_AXI_RREADY  = (state == ST_RRESP);
`else
  logic unused_rd;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_trig_cfg_sequencer.sv
// Self-checking bench for trig_cfg_sequencer: AXI4-Lite slave model, reference
// sequence model feeding expected queues, and a monitor that pops and compares.
module tb_trig_cfg_sequencer;
  import trig_cfg_pkg::*;

  localparam int NUM_REGS  = 4;
  localparam int BASE_ADDR = 0;
  localparam int AW        = 4;
  localparam int IDX_W     = 2;
`ifdef TRIG_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic                   ACLK, ARESETN, start;
  logic [NUM_REGS*32-1:0] cfg_data;
  logic                   busy, done, err;
  logic [IDX_W-1:0]       err_idx;
  state_e                 dbg_state;
  logic [AW-1:0]          M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]             M_AXI_AWPROT, M_AXI_ARPROT;
  logic                   M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0]            M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]             M_AXI_WSTRB;
  logic [1:0]             M_AXI_BRESP, M_AXI_RRESP;
  logic                   M_AXI_BVALID, M_AXI_BREADY;
  logic                   M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;

  trig_cfg_sequencer #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx), .dbg_state(dbg_state),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [AW-1:0]    exp_aw_q[$];
  logic [31:0]      exp_w_q[$];
  logic [AW-1:0]    exp_ar_q[$];
  logic [IDX_W:0]   exp_done_q[$];

  // slave behaviour knobs
  int aw_hold = 1;
  int w_hold  = 1;
  int bad_b   = -1;
  int bad_r   = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen with no expectation queued", name);
  endtask

  // ---------------- reference model ----------------
  task automatic expect_sequence(input logic [NUM_REGS*32-1:0] vals, output int fail);
    logic [IDX_W:0] e;
    logic [31:0]    rval;
    fail = -1;
    for (int k = 0; k < NUM_REGS && fail < 0; k++) begin
      exp_aw_q.push_back(AW'(BASE_ADDR + 4 * k));
      exp_w_q.push_back(vals[32*k +: 32]);
      if (k == bad_b) fail = k;
    end
    if (READBACK && fail < 0) begin
      for (int k = 0; k < NUM_REGS && fail < 0; k++) begin
        exp_ar_q.push_back(AW'(BASE_ADDR + 4 * k));
        rval = (k == bad_r) ? 32'hDEAD : vals[32*k +: 32];
        if (rval != vals[32*k +: 32]) fail = k;
      end
    end
    e[IDX_W]         = (fail >= 0);
    e[IDX_W-1:0]     = (fail >= 0) ? IDX_W'(fail) : '0;
    exp_done_q.push_back(e);
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [NUM_REGS];
  int  aw_cnt, w_cnt, wr_idx, rd_idx;
  bit  aw_got, w_got, b_hs, ar_got, r_hs;
  logic [31:0] wdat;

  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; b_hs = 0; ar_got = 0; r_hs = 0;
    wr_idx = 0; rd_idx = 0; wdat = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
        M_AXI_RVALID = 0; aw_cnt = 0; w_cnt = 0;
        aw_got = 0; w_got = 0; b_hs = 0; ar_got = 0; r_hs = 0;
      end else begin
        if (M_AXI_AWVALID && !aw_got) begin
          aw_cnt++;
          M_AXI_AWREADY = (aw_cnt >= aw_hold);
        end else begin
          aw_cnt = 0;
          M_AXI_AWREADY = 0;
        end
        if (M_AXI_WVALID && !w_got) begin
          w_cnt++;
          M_AXI_WREADY = (w_cnt >= w_hold);
        end else begin
          w_cnt = 0;
          M_AXI_WREADY = 0;
        end
        if (b_hs) begin
          M_AXI_BVALID = 0;
          b_hs = 0;
        end else if (aw_got && w_got && !M_AXI_BVALID) begin
          mem[wr_idx]  = wdat;
          M_AXI_BVALID = 1;
          M_AXI_BRESP  = (wr_idx == bad_b) ? 2'b10 : 2'b00;
          aw_got = 0;
          w_got  = 0;
        end
        M_AXI_ARREADY = M_AXI_ARVALID && !ar_got && ($urandom_range(0, 1) == 1);
        if (r_hs) begin
          M_AXI_RVALID = 0;
          r_hs = 0;
        end else if (ar_got && !M_AXI_RVALID) begin
          M_AXI_RVALID = 1;
          M_AXI_RDATA  = (rd_idx == bad_r) ? 32'hDEAD : mem[rd_idx];
          M_AXI_RRESP  = 2'b00;
          ar_got = 0;
        end
      end
      #4;
      if (ARESETN) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_got = 1;
          wr_idx = (int'(M_AXI_AWADDR) - BASE_ADDR) / 4;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          w_got = 1;
          wdat  = M_AXI_WDATA;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_hs = 1;
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_got = 1;
          rd_idx = (int'(M_AXI_ARADDR) - BASE_ADDR) / 4;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) r_hs = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  int aw_run = 0;
  int w_run  = 0;
  bit aw_stall = 0;
  bit w_stall  = 0;
  logic [AW-1:0] stall_addr;
  logic [31:0]   stall_data;
  logic [IDX_W:0] e_done;

  initial begin
    forever begin
      @(negedge ACLK);
      #4;
      if (!ARESETN) begin
        aw_run = 0; w_run = 0; aw_stall = 0; w_stall = 0;
        continue;
      end
      if (aw_stall) check("aw_stable", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, stall_addr});
      if (w_stall)  check("w_stable",  {M_AXI_WVALID, M_AXI_WDATA},   {1'b1, stall_data});
      aw_stall   = M_AXI_AWVALID && !M_AXI_AWREADY;
      w_stall    = M_AXI_WVALID && !M_AXI_WREADY;
      stall_addr = M_AXI_AWADDR;
      stall_data = M_AXI_WDATA;
      if (M_AXI_AWVALID) aw_run++;
      if (M_AXI_WVALID)  w_run++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (exp_aw_q.size() == 0) unexpected("aw_extra");
        else check("aw_addr", M_AXI_AWADDR, exp_aw_q.pop_front());
        check("aw_prot", M_AXI_AWPROT, 0);
        check("aw_hold_cycles", aw_run, aw_hold);
        aw_run = 0;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (exp_w_q.size() == 0) unexpected("w_extra");
        else check("w_data", M_AXI_WDATA, exp_w_q.pop_front());
        check("w_strb", M_AXI_WSTRB, 4'hF);
        check("w_hold_cycles", w_run, w_hold);
        w_run = 0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (exp_ar_q.size() == 0) unexpected("ar_extra");
        else check("ar_addr", M_AXI_ARADDR, exp_ar_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", busy, 0);
        if (exp_done_q.size() == 0) unexpected("done_extra");
        else begin
          e_done = exp_done_q.pop_front();
          check("done_err", err, e_done[IDX_W]);
          if (e_done[IDX_W]) check("done_err_idx", err_idx, e_done[IDX_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NUM_REGS*32-1:0] rand_vals();
    logic [NUM_REGS*32-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_pulse(input logic [NUM_REGS*32-1:0] vals);
    @(negedge ACLK);
    cfg_data = vals;
    start    = 1'b1;
    @(negedge ACLK);
    start    = 1'b0;
    cfg_data = rand_vals();
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  task automatic finish_seq(input int fail);
    int base;
    base = done_cnt;
    for (int i = 0; i < 400 && done_cnt == base; i++) @(negedge ACLK);
    check("done_seen", done_cnt - base, 1);
    repeat (4) @(negedge ACLK);
    check("single_done", done_cnt - base, 1);
    check("err_sticky", err, fail >= 0);
    check("queues_drained",
          exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_done_q.size(), 0);
  endtask

  task automatic run_seq(input logic [NUM_REGS*32-1:0] vals,
                         input int awh, input int wh, input int bb, input int br);
    int fail;
    aw_hold = awh; w_hold = wh; bad_b = bb; bad_r = br;
    expect_sequence(vals, fail);
    start_pulse(vals);
    finish_seq(fail);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [NUM_REGS*32-1:0] v;
    int fail, base, kind;
    ARESETN  = 1'b0;
    start    = 1'b0;
    cfg_data = '0;
    repeat (3) @(negedge ACLK);
    check("rst_outputs",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
           busy, done, err, err_idx, M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // ideal slave, registers 1..4
    run_seq({32'h4, 32'h3, 32'h2, 32'h1}, 1, 1, -1, -1);
    // write error on register 2
    run_seq(rand_vals(), 1, 1, 2, -1);
    // readback corruption on register 3 (plain completion without readback)
    run_seq(rand_vals(), 1, 1, -1, 3);
    // AWREADY three cycles late, WREADY immediate
    run_seq(rand_vals(), 3, 1, -1, -1);

    // second start while a write response is pending
    aw_hold = 1; w_hold = 1; bad_b = -1; bad_r = -1;
    v = rand_vals();
    expect_sequence(v, fail);
    start_pulse(v);
    for (int i = 0; i < 50 && !M_AXI_BREADY; i++) @(negedge ACLK);
    check("wresp_reached", M_AXI_BREADY, 1);
    start    = 1'b1;
    cfg_data = rand_vals();
    @(negedge ACLK);
    start = 1'b0;
    finish_seq(fail);

    // reset mid-sequence, then a full clean run
    v = rand_vals();
    expect_sequence(v, fail);
    start_pulse(v);
    for (int i = 0; i < 100; i++) begin
      if (READBACK ? M_AXI_ARVALID : M_AXI_BREADY) break;
      @(negedge ACLK);
    end
    check("reset_point_reached", READBACK ? M_AXI_ARVALID : M_AXI_BREADY, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_clears",
          {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_RREADY, busy}, 0);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_done_q.delete();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    run_seq(rand_vals(), 1, 1, -1, -1);

    // randomized sequences
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 3);
      run_seq(rand_vals(), $urandom_range(1, 4), $urandom_range(1, 4),
              (kind == 1) ? $urandom_range(0, NUM_REGS - 1) : -1,
              (kind == 2) ? $urandom_range(0, NUM_REGS - 1) : -1);
    end

    base = done_cnt;
    repeat (10) @(negedge ACLK);
    check("idle_no_done", done_cnt - base, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trig_cfg_sequencer.md
TRIG_CFG_SEQUENCER -- requirements
Module: trig_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of consecutive 32-bit trigger registers configured.
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address of register 0.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI4-Lite address width.
REQ-004 SHALL have port ACLK, in, 1, the single clock.
REQ-005 SHALL have port ARESETN, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, in, 1, single-cycle request to begin a configuration sequence.
REQ-007 SHALL have port cfg_data, in, NUM_REGS*32, register values; register k in bits [32k+31:32k].
REQ-008 SHALL have ports busy, done and err, each out, 1: sequence in progress, one-cycle completion pulse, and sticky failure flag.
REQ-009 SHALL have port err_idx, out, $clog2(NUM_REGS), index of the failing register.
REQ-010 SHALL have AW channel ports M_AXI_AWADDR out C_M_AXI_ADDR_WIDTH, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1 and M_AXI_AWREADY in 1.
REQ-011 SHALL have W channel ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1 and M_AXI_WREADY in 1.
REQ-012 SHALL have B channel ports M_AXI_BRESP in 2, M_AXI_BVALID in 1 and M_AXI_BREADY out 1.
REQ-013 SHALL have AR and R channel ports M_AXI_ARADDR out, M_AXI_ARPROT out 3, M_AXI_ARVALID out, M_AXI_ARREADY in, M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in and M_AXI_RREADY out.

Function
REQ-014 SHALL implement the FSM IDLE -> WADDR -> WRESP -> (next register or RADDR) -> RRESP -> (next register or DONE) -> IDLE.
REQ-015 SHALL, when start=1 in IDLE, latch cfg_data, clear err, set busy the next cycle and go to WADDR with index 0.
REQ-016 SHALL ignore start when not in IDLE; cfg_data changes after latching SHALL have no effect.
REQ-017 SHALL, in WADDR, assert AWVALID and WVALID together, with AWADDR = BASE_ADDR + 4*idx, WDATA = latched value, WSTRB = 4'hF and AWPROT = 0.
REQ-018 SHALL drop AWVALID and WVALID independently after each one's own handshake, and leave WADDR only when both have completed.
REQ-019 SHALL hold BREADY=1 in WRESP; on BVALID with BRESP != 2'b00 it SHALL set err, load err_idx=idx and go to DONE; otherwise it SHALL advance idx or, at the last register, go to RADDR with idx=0.
REQ-020 SHALL, in RADDR, hold ARVALID with ARADDR = BASE_ADDR + 4*idx until ARREADY, and hold RREADY=1 in RRESP.
REQ-021 SHALL, on RVALID, fail if RRESP != 0 or RDATA != the latched value, recording err and err_idx exactly as on a write failure.
REQ-022 SHALL abort at the first failure, issuing no further AXI transactions.
REQ-023 SHALL pulse done for exactly one cycle in DONE, deassert busy that same cycle, and return to IDLE.
REQ-024 SHALL hold each VALID stable until its handshake and SHALL never assert VALID combinationally from READY.

Reset
REQ-025 SHALL, while ARESETN=0, asynchronously force state=IDLE, all VALID/READY outputs, busy, done, err and err_idx to 0, and AWADDR/ARADDR/WDATA to 0.
REQ-026 SHALL, on reset mid-sequence, drop outstanding transactions without completing them and perform no recovery.

Configuration
REQ-027 SHALL compile in readback verification only when macro TRIG_CFG_READBACK_EN is defined.
REQ-028 SHALL, when TRIG_CFG_READBACK_EN is undefined, go from the last WRESP directly to DONE, tie ARVALID and RREADY to 0, and report only BRESP errors.

Structure
REQ-029 SHALL place the FSM state enum, the AXI response constants (OKAY=2'b00, SLVERR=2'b10) and REG_STRIDE=4 in the shared package trig_cfg_pkg.
REQ-030 SHALL remain a single module with no sub-modules.

Verification
REQ-031 SHALL verify that cfg_data={32'h4,32'h3,32'h2,32'h1}, BASE_ADDR=0 and an ideal slave produce writes 0x0..0xC with data 1..4, four matching reads, one done pulse and err=0.
REQ-032 SHALL verify that a slave returning BRESP=SLVERR on register 2 gives err=1, err_idx=2, no AW for register 3 and a done pulse.
REQ-033 SHALL verify that readback returning RDATA=32'hDEAD for register 3 gives err=1 and err_idx=3.
REQ-034 SHALL verify that with AWREADY delayed 3 cycles and WREADY immediate, WVALID falls after 1 cycle, AWVALID is held 3 cycles, and exactly one write occurs per register.
REQ-035 SHALL verify that a second start pulsed during WRESP causes no restart and produces only one done pulse.
REQ-036 SHALL verify that ARESETN low during RADDR clears ARVALID and busy immediately, and that a following start runs the full sequence from register 0.
